// File: rtl/ram_dp_be.sv
// ram_dp_be: true-dual-port RAM on one clock with per-byte write lanes,
// read-first behaviour, optional output register and a zero-fill engine.
// Port A has priority over port B on any lane that both write in one cycle.
module ram_dp_be #(
  parameter int DATAWIDTH = 64,
  parameter int ADDRWIDTH = 10,
  parameter int BYTEWIDTH = 8,
  parameter int OUTREG    = 0,
  parameter int INITCLEAR = 1,
  localparam int NUMBYTES = DATAWIDTH / BYTEWIDTH,
  localparam int MEMDEPTH = 2 ** ADDRWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 PortAEnable,
  input  logic                 PortAWriteEnable,
  input  logic [ADDRWIDTH-1:0] PortAAddr,
  input  logic [DATAWIDTH-1:0] PortADataIn,
  input  logic [NUMBYTES-1:0]  PortAByteEn,
  output logic [DATAWIDTH-1:0] PortADataOut,
  output logic                 PortAValid,
  input  logic                 PortBEnable,
  input  logic                 PortBWriteEnable,
  input  logic [ADDRWIDTH-1:0] PortBAddr,
  input  logic [DATAWIDTH-1:0] PortBDataIn,
  input  logic [NUMBYTES-1:0]  PortBByteEn,
  output logic [DATAWIDTH-1:0] PortBDataOut,
  output logic                 PortBValid,
  input  logic                 ClearReq,
  output logic                 ClearBusy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (INITCLEAR != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDRWIDTH-1:0] CNT_LAST = ADDRWIDTH'(MEMDEPTH - 1);

  logic [DATAWIDTH-1:0] mem [MEMDEPTH];

  logic [0:0]           state_d, state_q;
  logic [ADDRWIDTH-1:0] cnt_d, cnt_q;
  logic                 clr_busy_s;
  logic                 acc_ok_s;

  // Per-port views so both ports share one description
  logic                 en_s   [2];
  logic                 we_s   [2];
  logic [ADDRWIDTH-1:0] addr_s [2];
  logic [DATAWIDTH-1:0] din_s  [2];
  logic [NUMBYTES-1:0]  be_s   [2];
  logic                 rd_s   [2];
  logic                 wr_s   [2];

  logic                 vld1_d [2];
  logic                 vld1_q [2];
  logic [DATAWIDTH-1:0] dat1_d [2];
  logic [DATAWIDTH-1:0] dat1_q [2];

  assign en_s[0]   = PortAEnable;
  assign en_s[1]   = PortBEnable;
  assign we_s[0]   = PortAWriteEnable;
  assign we_s[1]   = PortBWriteEnable;
  assign addr_s[0] = PortAAddr;
  assign addr_s[1] = PortBAddr;
  assign din_s[0]  = PortADataIn;
  assign din_s[1]  = PortBDataIn;
  assign be_s[0]   = PortAByteEn;
  assign be_s[1]   = PortBByteEn;

  assign clr_busy_s = (state_q == ST_CLEAR);
  assign ClearBusy  = clr_busy_s;
  // Port traffic is dropped while clearing or held in reset
  assign acc_ok_s   = !Rst && !clr_busy_s;

  // Decode each port request into a read or a write strobe
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_s[p] = acc_ok_s && en_s[p] && !we_s[p];
      wr_s[p] = acc_ok_s && en_s[p] && we_s[p];
    end
  end

  // Clear engine next state: one zero write per cycle, stop after the last word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ClearReq) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear engine state and address counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array update: clear word, else B lanes then A lanes so A wins shared lanes
  always_ff @(posedge Clk) begin
    if (clr_busy_s && !Rst) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NUMBYTES; i++) begin
        if (wr_s[1] && be_s[1][i]) begin
          mem[addr_s[1]][i*BYTEWIDTH +: BYTEWIDTH] <= din_s[1][i*BYTEWIDTH +: BYTEWIDTH];
        end
        if (wr_s[0] && be_s[0][i]) begin
          mem[addr_s[0]][i*BYTEWIDTH +: BYTEWIDTH] <= din_s[0][i*BYTEWIDTH +: BYTEWIDTH];
        end
      end
    end
  end

  // First read stage: capture the pre-write word, hold data when idle
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      vld1_d[p] = rd_s[p];
      if (rd_s[p]) begin
        dat1_d[p] = mem[addr_s[p]];
      end else begin
        dat1_d[p] = dat1_q[p];
      end
    end
  end

  // First read stage registers, flushed by reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int p = 0; p < 2; p++) begin
        vld1_q[p] <= 1'b0;
        dat1_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld1_q[p] <= vld1_d[p];
        dat1_q[p] <= dat1_d[p];
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic                 vld2_d [2];
    logic                 vld2_q [2];
    logic [DATAWIDTH-1:0] dat2_d [2];
    logic [DATAWIDTH-1:0] dat2_q [2];

    // Second read stage: forward only fresh data, otherwise hold
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        vld2_d[p] = vld1_q[p];
        if (vld1_q[p]) begin
          dat2_d[p] = dat1_q[p];
        end else begin
          dat2_d[p] = dat2_q[p];
        end
      end
    end

    // Second read stage registers, flushed by reset
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        for (int p = 0; p < 2; p++) begin
          vld2_q[p] <= 1'b0;
          dat2_q[p] <= '0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          vld2_q[p] <= vld2_d[p];
          dat2_q[p] <= dat2_d[p];
        end
      end
    end

    assign PortADataOut = dat2_q[0];
    assign PortAValid   = vld2_q[0];
    assign PortBDataOut = dat2_q[1];
    assign PortBValid   = vld2_q[1];
  end else begin : g_direct
    assign PortADataOut = dat1_q[0];
    assign PortAValid   = vld1_q[0];
    assign PortBDataOut = dat1_q[1];
    assign PortBValid   = vld1_q[1];
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: directed vector table plus randomized traffic, every cycle
// compared against a word-level memory model with a read-latency delay line.
module tb_ram_dp_be;
  parameter int OUTREG = 0;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 8;
  localparam int NB = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en   [2];
  logic          we   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];
  logic [NB-1:0] be   [2];
  logic [DW-1:0] dout [2];
  logic          vld  [2];
  logic          clr_req;
  logic          busy;

  // Reference model state
  logic [DW-1:0] mm [DEPTH];
  int            clr_left;
  int            clr_ptr;
  logic          exp_vld [2];
  logic [DW-1:0] exp_dat [2];
  logic          s1_vld  [2];
  logic [DW-1:0] s1_dat  [2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          en_a, we_a;
    logic [AW-1:0] ad_a;
    logic [DW-1:0] d_a;
    logic [NB-1:0] be_a;
    logic          en_b, we_b;
    logic [AW-1:0] ad_b;
    logic [DW-1:0] d_b;
    logic [NB-1:0] be_b;
    logic          ck_a;
    logic [DW-1:0] ex_a;
    logic          ck_b;
    logic [DW-1:0] ex_b;
  } vec_t;

  vec_t tbl [14];

  ram_dp_be #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(BW), .OUTREG(OUTREG), .INITCLEAR(1)
  ) dut (
    .Clk(clk), .Rst(rst),
    .PortAEnable(en[0]), .PortAWriteEnable(we[0]), .PortAAddr(addr[0]),
    .PortADataIn(din[0]), .PortAByteEn(be[0]), .PortADataOut(dout[0]), .PortAValid(vld[0]),
    .PortBEnable(en[1]), .PortBWriteEnable(we[1]), .PortBAddr(addr[1]),
    .PortBDataIn(din[1]), .PortBByteEn(be[1]), .PortBDataOut(dout[1]), .PortBValid(vld[1]),
    .ClearReq(clr_req), .ClearBusy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic [NB-1:0] ba,
    input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db, input logic [NB-1:0] bb,
    input logic ca, input logic [DW-1:0] xa, input logic cb, input logic [DW-1:0] xb);
    vec_t v;
    v.en_a = ea; v.we_a = wa; v.ad_a = aa; v.d_a = da; v.be_a = ba;
    v.en_b = eb; v.we_b = wb; v.ad_b = ab; v.d_b = db; v.be_b = bb;
    v.ck_a = ca; v.ex_a = xa; v.ck_b = cb; v.ex_b = xb;
    return v;
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      if (m[i]) r = r | (32'hFF << (i * BW));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      en[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; din[p] = '0; be[p] = '0;
    end
    clr_req = 1'b0;
  endtask

  // One clock: advance the model on the current inputs, then compare all outputs.
  task automatic cycle();
    logic          busy_m;
    logic          rd  [2];
    logic [DW-1:0] old [2];
    logic [DW-1:0] m;
    busy_m = (clr_left > 0);
    for (int p = 0; p < 2; p++) begin
      rd[p]  = en[p] && !we[p] && !busy_m;
      old[p] = mm[addr[p]];
    end
    if (busy_m) begin
      mm[clr_ptr] = '0;
      clr_ptr++;
      clr_left--;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        if (en[p] && we[p]) begin
          m = lane_mask(be[p]);
          mm[addr[p]] = (mm[addr[p]] & ~m) | (din[p] & m);
        end
      end
      if (clr_req) begin
        clr_left = DEPTH;
        clr_ptr  = 0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (OUTREG != 0) begin
        exp_vld[p] = s1_vld[p];
        if (s1_vld[p]) exp_dat[p] = s1_dat[p];
        s1_vld[p] = rd[p];
        if (rd[p]) s1_dat[p] = old[p];
      end else begin
        exp_vld[p] = rd[p];
        if (rd[p]) exp_dat[p] = old[p];
      end
    end
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(clr_left > 0));
    chk("valid_a", 32'(vld[0]), 32'(exp_vld[0]));
    chk("valid_b", 32'(vld[1]), 32'(exp_vld[1]));
    chk("data_a", dout[0], exp_dat[0]);
    chk("data_b", dout[1], exp_dat[1]);
  endtask

  // Assert reset mid-cycle, check the asynchronous reset values, then release.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_data_a", dout[0], 32'h0);
    chk("rst_data_b", dout[1], 32'h0);
    chk("rst_valid", 32'({vld[1], vld[0]}), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clr_left = DEPTH;
    clr_ptr  = 0;
    for (int p = 0; p < 2; p++) begin
      exp_vld[p] = 1'b0; exp_dat[p] = '0; s1_vld[p] = 1'b0; s1_dat[p] = '0;
    end
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      en[0] = 1'b1; addr[0] = AW'(i);
      cycle();
      idle();
      if (OUTREG != 0) cycle();
      chk(name, dout[0], 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    tbl[0]  = mk(1,1,4'd3, 32'h11223344,4'hF, 0,0,4'd0,32'h0,4'h0,         0,32'h0,       0,32'h0);
    tbl[1]  = mk(1,1,4'd3, 32'hAABBCCDD,4'h5, 0,0,4'd0,32'h0,4'h0,         0,32'h0,       0,32'h0);
    tbl[2]  = mk(0,0,4'd0, 32'h0,4'h0,        1,0,4'd3,32'h0,4'h0,         0,32'h0,       1,32'h11BB33DD);
    tbl[3]  = mk(1,1,4'd5, 32'hAAAAAAAA,4'h3, 1,1,4'd5,32'hBBBBBBBB,4'h6,  0,32'h0,       0,32'h0);
    tbl[4]  = mk(1,0,4'd5, 32'h0,4'h0,        0,0,4'd0,32'h0,4'h0,         1,32'h00BBAAAA,0,32'h0);
    tbl[5]  = mk(1,1,4'd7, 32'h12345678,4'hF, 0,0,4'd0,32'h0,4'h0,         0,32'h0,       0,32'h0);
    tbl[6]  = mk(1,1,4'd7, 32'hCAFEF00D,4'hF, 1,0,4'd7,32'h0,4'h0,         0,32'h0,       1,32'h12345678);
    tbl[7]  = mk(1,0,4'd7, 32'h0,4'h0,        0,0,4'd0,32'h0,4'h0,         1,32'hCAFEF00D,0,32'h0);
    tbl[8]  = mk(1,1,4'd3, 32'hFFFFFFFF,4'h0, 0,0,4'd0,32'h0,4'h0,         0,32'h0,       0,32'h0);
    tbl[9]  = mk(0,0,4'd0, 32'h0,4'h0,        1,0,4'd3,32'h0,4'h0,         0,32'h0,       1,32'h11BB33DD);
    tbl[10] = mk(1,0,4'd3, 32'h0,4'h0,        1,1,4'd3,32'h0,4'hF,         1,32'h11BB33DD,0,32'h0);
    tbl[11] = mk(1,0,4'd3, 32'h0,4'h0,        1,0,4'd5,32'h0,4'h0,         1,32'h0,       1,32'h00BBAAAA);
    tbl[12] = mk(1,1,4'd15,32'hDEADBEEF,4'hF, 1,1,4'd0,32'h01020304,4'hF,  0,32'h0,       0,32'h0);
    tbl[13] = mk(1,0,4'd0, 32'h0,4'h0,        1,0,4'd15,32'h0,4'h0,        1,32'h01020304,1,32'hDEADBEEF);

    idle();
    #2;
    apply_reset();

    // Initial clear: busy for exactly DEPTH cycles from release
    busy_cnt = 32'(busy);
    for (int k = 0; k < DEPTH + 4; k++) begin
      cycle();
      busy_cnt += 32'(busy);
    end
    chk("init_clear_len", 32'(busy_cnt), 32'(DEPTH));
    read_all_zero("init_zero");

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      en[0] = tbl[i].en_a; we[0] = tbl[i].we_a; addr[0] = tbl[i].ad_a; din[0] = tbl[i].d_a; be[0] = tbl[i].be_a;
      en[1] = tbl[i].en_b; we[1] = tbl[i].we_b; addr[1] = tbl[i].ad_b; din[1] = tbl[i].d_b; be[1] = tbl[i].be_b;
      clr_req = 1'b0;
      cycle();
      idle();
      if (OUTREG != 0) cycle();
      if (tbl[i].ck_a) chk($sformatf("vec%0d_a", i), dout[0], tbl[i].ex_a);
      if (tbl[i].ck_b) chk($sformatf("vec%0d_b", i), dout[1], tbl[i].ex_b);
    end

    // Populate, then ClearReq with a dropped write and a second request mid-clear
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      en[0] = 1'b1; we[0] = 1'b1; addr[0] = AW'(i); din[0] = $urandom; be[0] = 4'hF;
      cycle();
    end
    busy_cnt = 0;
    for (int k = 0; k < DEPTH + 6; k++) begin
      idle();
      clr_req = (k == 0) || (k == 8);
      if (k == 5) begin
        en[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd2; din[0] = 32'h55555555; be[0] = 4'hF;
      end
      cycle();
      busy_cnt += 32'(busy);
    end
    chk("req_clear_len", 32'(busy_cnt), 32'(DEPTH));
    read_all_zero("req_zero");

    // Reset with the clear counter at 9
    idle();
    clr_req = 1'b1;
    cycle();
    idle();
    repeat (9) cycle();
    apply_reset();
    busy_cnt = 32'(busy);
    for (int k = 0; k < DEPTH + 4; k++) begin
      cycle();
      busy_cnt += 32'(busy);
    end
    chk("rst_clear_len", 32'(busy_cnt), 32'(DEPTH));

    // Reset while a read is in flight: no valid may follow
    en[0] = 1'b1; addr[0] = 4'd7; en[1] = 1'b1; addr[1] = 4'd9;
    cycle();
    idle();
    apply_reset();
    repeat (DEPTH + 4) cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        en[p]   = ($urandom_range(0, 3) != 0);
        we[p]   = $urandom_range(0, 1) == 1;
        addr[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
        din[p]  = $urandom;
        be[p]   = NB'($urandom_range(0, 15));
      end
      clr_req = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
